// File: rtl/error_subtractor_if.sv
// error_subtractor_if: input pair / output beat handshake bundle for error_subtractor.
// slave = the subtractor's view, master = the producer/consumer side.
interface error_subtractor_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     d_in;
  logic [W-1:0]     y_in;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     e_out;
  logic             sat_flag;
  logic [CNT_W-1:0] sat_count;

  modport master (
    output in_valid, d_in, y_in, out_ready,
    input  in_ready, out_valid, e_out, sat_flag, sat_count
  );

  modport slave (
    input  in_valid, d_in, y_in, out_ready,
    output in_ready, out_valid, e_out, sat_flag, sat_count
  );
endinterface

// File: rtl/error_subtractor.sv
// error_subtractor: two-stage pipelined ANC error node, e = d - y, with
// valid/ready backpressure, overflow flagging and a saturating overflow counter.
// Optional build macro ERRSUB_SATURATE_EN: clamp e_out on overflow instead of
// letting it wrap (flag and counter behave the same either way).
module error_subtractor #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  error_subtractor_if.slave bus
);

  logic signed [W-1:0] d_q, y_q;
  logic                s1_valid_q;
  logic [W-1:0]        e_q, e_d;
  logic                sat_q, sat_d;
  logic                out_valid_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                stall;
  logic                in_fire;
  logic                out_fire;
  logic signed [W:0]   diff;

  assign stall    = out_valid_q && !bus.out_ready;
  assign in_fire  = bus.in_valid && !stall;
  assign out_fire = out_valid_q && bus.out_ready;

  // Full-precision difference of the S1 operands, overflow test and output select.
  always_comb begin
    diff  = {d_q[W-1], d_q} - {y_q[W-1], y_q};
    // The W+1 result fits in W bits exactly when its top two bits agree.
    sat_d = diff[W] != diff[W-1];
    e_d   = diff[W-1:0];
`ifdef ERRSUB_SATURATE_EN
    if (sat_d) begin
      e_d = diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

  // Overflow event counter that sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (out_fire && sat_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Stage 1: capture the operand pair; holds while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      d_q        <= '0;
      y_q        <= '0;
    end else if (!stall) begin
      s1_valid_q <= in_fire;
      if (in_fire) begin
        d_q <= bus.d_in;
        y_q <= bus.y_in;
      end
    end
  end

  // Stage 2: register the result beat; holds while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      e_q         <= '0;
      sat_q       <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= s1_valid_q;
      e_q         <= e_d;
      sat_q       <= sat_d;
    end
  end

  // Count delivered beats that overflowed.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.in_ready  = !stall;
  assign bus.out_valid = out_valid_q;
  assign bus.e_out     = e_q;
  assign bus.sat_flag  = sat_q;
  assign bus.sat_count = cnt_q;

endmodule

// File: tb/tb_error_subtractor.sv
// tb_error_subtractor: randomized and directed stimulus for error_subtractor,
// checked against a queue-based reference model. Two instances share stimulus:
// one with a 16-bit overflow counter, one with a 2-bit counter.
module tb_error_subtractor;

  localparam int W  = 16;
  localparam int MX = (1 << (W - 1)) - 1;
  localparam int MN = -(1 << (W - 1));

  typedef struct {
    logic [W-1:0] e;
    logic         f;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  error_subtractor_if #(.W(W), .CNT_W(16)) b16 ();
  error_subtractor_if #(.W(W), .CNT_W(2))  b2 ();

  error_subtractor #(.W(W), .CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  error_subtractor #(.W(W), .CNT_W(2))  dut2  (.clk(clk), .rst(rst), .bus(b2));

  always #5 clk = ~clk;

  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  int           cnt16 = 0;
  int           cnt2  = 0;
  bit           chk_lat = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_e;
  logic         prev_f;
  logic [W-1:0] last_e;
  exp_t         exp_q[$];
  logic [W-1:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: e = d - y in plain integer arithmetic.
  function automatic exp_t ref_calc(input int d, input int y);
    exp_t         r;
    logic [W-1:0] dv, yv;
    int           diff;
    dv   = W'(d);
    yv   = W'(y);
    diff = int'(signed'(dv)) - int'(signed'(yv));
    r.f  = (diff > MX) || (diff < MN);
    r.e  = W'(diff);
`ifdef ERRSUB_SATURATE_EN
    if (diff > MX) r.e = W'(MX);
    if (diff < MN) r.e = W'(MN);
`endif
    r.acc = 0;
    return r;
  endfunction

  task automatic step(input bit iv, input int d, input int y, input bit ordy, output bit acc);
    exp_t ex;
    logic ir, ov;
    @(negedge clk);
    b16.in_valid = iv;  b16.d_in = W'(d); b16.y_in = W'(y); b16.out_ready = ordy;
    b2.in_valid  = iv;  b2.d_in  = W'(d); b2.y_in  = W'(y); b2.out_ready  = ordy;
    #1;
    ir = b16.in_ready;
    ov = b16.out_valid;
    check("cnt16", 32'(b16.sat_count), cnt16);
    check("cnt2", 32'(b2.sat_count), cnt2);
    check("in_ready", 32'(ir), 32'(!(ov && !ordy)));
    check("twin_valid", 32'(b2.out_valid), 32'(ov));
    if (prev_stall) begin
      check("hold_valid", 32'(ov), 1);
      check("hold_e", 32'(b16.e_out), 32'(prev_e));
      check("hold_flag", 32'(b16.sat_flag), 32'(prev_f));
    end
    if (ov && ordy) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 1, 0);
      end else begin
        ex = exp_q.pop_front();
        check("e_out", 32'(b16.e_out), 32'(ex.e));
        check("sat_flag", 32'(b16.sat_flag), 32'(ex.f));
        if (chk_lat) check("latency", cyc - ex.acc, 2);
        last_e = b16.e_out;
        got_q.push_back(b16.e_out);
        if (ex.f) begin
          if (cnt16 < 65535) cnt16++;
          if (cnt2 < 3) cnt2++;
        end
      end
    end
    acc = iv && ir;
    if (acc) begin
      ex     = ref_calc(d, y);
      ex.acc = cyc;
      exp_q.push_back(ex);
    end
    prev_stall = ov && !ordy;
    prev_e     = b16.e_out;
    prev_f     = b16.sat_flag;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    b16.in_valid = 1'b0;
    b2.in_valid  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(b16.out_valid), 0);
    check("rst_cnt16", 32'(b16.sat_count), 0);
    check("rst_cnt2", 32'(b2.sat_count), 0);
    check("rst_e", 32'(b16.e_out), 0);
    check("rst_flag", 32'(b16.sat_flag), 0);
    exp_q.delete();
    got_q.delete();
    cnt16 = 0;
    cnt2 = 0;
    prev_stall = 1'b0;
    cyc++;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b1, a);
  endtask

  function automatic int pick();
    case ($urandom_range(0, 5))
      0:       return MX;
      1:       return MN;
      2:       return 0;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  initial begin
    bit a;
    int k;
    rst = 1'b1;
    b16.in_valid = 1'b0; b16.d_in = '0; b16.y_in = '0; b16.out_ready = 1'b1;
    b2.in_valid  = 1'b0; b2.d_in  = '0; b2.y_in  = '0; b2.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    // Single beat and both overflow directions, latency checked.
    chk_lat = 1'b1;
    step(1'b1, 1000, 250, 1'b1, a);
    idle(3);
    check("beat_750", 32'(last_e), 750);
    step(1'b1, 30000, -10000, 1'b1, a);
    idle(3);
`ifdef ERRSUB_SATURATE_EN
    check("ovf_pos", 32'(last_e), 32'h7FFF);
`else
    check("ovf_pos", 32'(last_e), 32'h9C40);
`endif
    check("ovf_pos_cnt", 32'(b16.sat_count), 1);
    step(1'b1, -30000, 10000, 1'b1, a);
    idle(3);
`ifdef ERRSUB_SATURATE_EN
    check("ovf_neg", 32'(last_e), 32'h8000);
`else
    check("ovf_neg", 32'(last_e), 32'h63C0);
`endif

    // Backpressure: five pairs, out_ready low for 4 cycles mid-stream.
    chk_lat = 1'b0;
    do_reset();
    k = 1;
    for (int c = 0; c < 30 && got_q.size() < 5; c++) begin
      step(k <= 5, k * 100, k, !(c >= 3 && c < 7), a);
      if (a) k++;
    end
    check("bp_count", got_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) check("bp_seq", 32'(got_q[i]), 99 * (i + 1));
    end

    // Reset with both stages full, then a fresh beat.
    do_reset();
    step(1'b1, 11, 1, 1'b0, a);
    step(1'b1, 22, 2, 1'b0, a);
    step(1'b1, 33, 3, 1'b0, a);
    check("full_stall", 32'(b16.in_ready), 0);
    do_reset();
    chk_lat = 1'b1;
    step(1'b1, 7, 3, 1'b1, a);
    idle(3);
    check("post_rst_beat", 32'(last_e), 4);
    check("post_rst_empty", exp_q.size(), 0);

    // Counter saturation on the 2-bit instance.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 30000, -10000, 1'b1, a);
    idle(3);
    check("cnt2_sat", 32'(b2.sat_count), 3);
    check("cnt16_five", 32'(b16.sat_count), 5);

    // Randomized traffic.
    chk_lat = 1'b0;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, pick(), pick(), $urandom_range(0, 3) != 0, a);
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step(1'b0, 0, 0, 1'b1, a);
    check("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
